// File: rtl/sc_stream_ctrl.sv
// Run controller for one stochastic-computing evaluation window: drives the
// added-zero LFSR generators for a full period and counts ones in the returned bitstream.
module sc_stream_ctrl #(
    parameter int N        = 8,
    parameter int PIPE_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] seed_in,
    input  logic         sc_bit,
    output logic [N-1:0] seed,
    output logic         restart,
    output logic         enable,
    output logic         busy,
    output logic         done,
    output logic [N:0]   result,
    output logic         result_valid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // A zero-latency datapath still gets a one-bit delay line so the vector is never empty.
    localparam int         DW         = (PIPE_LAT > 0) ? PIPE_LAT : 1;
    localparam logic [2:0] DRAIN_LAST = 3'(DW - 1);
    localparam logic [2:0] DRAIN_ONE  = 3'd1;
    localparam logic [N-1:0] WIN_LAST = {N{1'b1}};
    localparam logic [N-1:0] WIN_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   ACC_ONE  = {{N{1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [N-1:0]   seed_q, seed_d;
    logic           restart_q, restart_d;
    logic           enable_q, enable_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N:0]     result_q, result_d;
    logic           result_valid_q, result_valid_d;
    logic [N-1:0]   win_cnt_q, win_cnt_d;
    logic [2:0]     drain_cnt_q, drain_cnt_d;
    logic [N:0]     acc_q, acc_d;
    logic [DW-1:0]  en_pipe_q, en_pipe_d;
    logic           sample_en;
    logic           in_window;

    always_comb begin
        state_d        = state_q;
        seed_d         = seed_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        win_cnt_d      = win_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        acc_d          = acc_q;

        // sc_bit lines up with enable delayed by the datapath latency.
        en_pipe_d = (en_pipe_q << 1) | DW'(enable_q);
        sample_en = (PIPE_LAT == 0) ? enable_q : en_pipe_q[DW-1];
        in_window = (state_q == RUN) || (state_q == DRAIN);

        if (in_window && sample_en && sc_bit) begin
            acc_d = acc_q + ACC_ONE;
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d        = LOAD;
                    seed_d         = seed_in;
                    result_valid_d = 1'b0;
                end
            end
            LOAD: begin
                win_cnt_d   = '0;
                drain_cnt_d = '0;
                acc_d       = '0;
                state_d     = RUN;
            end
            RUN: begin
                win_cnt_d = win_cnt_q + WIN_ONE;
                if (win_cnt_q == WIN_LAST) begin
                    state_d = (PIPE_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + DRAIN_ONE;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q == LOAD || state_q == RUN || state_q == DRAIN)) begin
            state_d = IDLE;
        end

        // The last sample lands on the same edge that enters DONE, so publish acc_d.
        if (state_d == DONE) begin
            result_d       = acc_d;
            result_valid_d = 1'b1;
        end

        restart_d = (state_d == LOAD);
        enable_d  = (state_d == RUN);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            seed_q         <= '0;
            restart_q      <= 1'b0;
            enable_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            win_cnt_q      <= '0;
            drain_cnt_q    <= '0;
            acc_q          <= '0;
            en_pipe_q      <= '0;
        end else begin
            state_q        <= state_d;
            seed_q         <= seed_d;
            restart_q      <= restart_d;
            enable_q       <= enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            win_cnt_q      <= win_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            acc_q          <= acc_d;
            en_pipe_q      <= en_pipe_d;
        end
    end

    assign seed         = seed_q;
    assign restart      = restart_q;
    assign enable       = enable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sc_stream_ctrl.sv
// Scoreboard bench for sc_stream_ctrl with N=4, PIPE_LAT=1: stimulus queues the
// expected count, done cycle and seed; a negedge monitor checks each done pulse.
module tb_sc_stream_ctrl;

    localparam int N        = 4;
    localparam int PIPE_LAT = 1;
    localparam int WIN      = 16;
    localparam int LAT      = WIN + PIPE_LAT + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [N-1:0] seed_in;
    logic         sc_bit;
    logic [N-1:0] seed;
    logic         restart;
    logic         enable;
    logic         busy;
    logic         done;
    logic [N:0]   result;
    logic         result_valid;

    typedef struct {
        int res;
        int done_cyc;
        int seed;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur;
    int           tests    = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           en_count = 0;
    int           overlap  = 0;
    logic [N-1:0] load_seed = '0;

    sc_stream_ctrl #(.N(N), .PIPE_LAT(PIPE_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .seed_in      (seed_in),
        .sc_bit       (sc_bit),
        .seed         (seed),
        .restart      (restart),
        .enable       (enable),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge and queue what the resulting done pulse must show.
    task automatic apply_stimulus(input logic [N-1:0] s, input int expected_res);
        seed_in = s;
        start   = 1'b1;
        exp_q.push_back('{expected_res, cyc + LAT + 1, int'(s)});
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        check_output("done_timeout", exp_q.size(), 0);
        tick(2);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (restart) begin
                en_count  = 0;
                load_seed = seed;
            end
            if (enable) en_count++;
            if (restart && enable) overlap = 1;
            if (done) begin
                check_output("done_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check_output("done_cycle", cyc, cur.done_cyc);
                    check_output("result", int'(result), cur.res);
                    check_output("result_valid", int'(result_valid), 1);
                    check_output("enable_cycles", en_count, WIN);
                    check_output("seed_at_load", int'(load_seed), cur.seed);
                    check_output("seed_at_done", int'(seed), cur.seed);
                    check_output("restart_enable_overlap", overlap, 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        sc_bit  = 1'b0;
        seed_in = '0;
        tick(3);
        check_output("rst_seed", int'(seed), 0);
        check_output("rst_restart", int'(restart), 0);
        check_output("rst_enable", int'(enable), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_result", int'(result), 0);
        check_output("rst_result_valid", int'(result_valid), 0);
        reset = 1'b1;
        tick(2);

        // All ones: full count of 2^N.
        sc_bit = 1'b1;
        apply_stimulus(4'h3, 16);
        check_output("load_restart", int'(restart), 1);
        check_output("load_enable", int'(enable), 0);
        check_output("load_busy", int'(busy), 1);
        check_output("load_seed", int'(seed), 3);
        wait_done();

        // All zeros.
        sc_bit = 1'b0;
        apply_stimulus(4'h7, 0);
        wait_done();

        // Ones in IDLE, LOAD and the first RUN cycle are outside the delayed window; r1..r5 count.
        sc_bit = 1'b1;
        tick(1);
        apply_stimulus(4'h9, 5);
        tick(7);
        sc_bit = 1'b0;
        wait_done();

        // Start during RUN is ignored.
        sc_bit = 1'b1;
        apply_stimulus(4'h5, 16);
        tick(5);
        start = 1'b1;
        tick(3);
        start = 1'b0;
        wait_done();

        // Held start: two runs, done pulses 20 cycles apart.
        seed_in = 4'h6;
        start   = 1'b1;
        exp_q.push_back('{16, cyc + LAT + 1, 6});
        exp_q.push_back('{16, cyc + 2 * LAT + 3, 6});
        tick(25);
        start = 1'b0;
        wait_done();

        // Abort in RUN cycle 7.
        seed_in = 4'hC;
        start   = 1'b1;
        tick(1);
        start = 1'b0;
        tick(8);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_enable", int'(enable), 0);
        check_output("abort_restart", int'(restart), 0);
        check_output("abort_result_kept", int'(result), 16);
        check_output("abort_result_valid", int'(result_valid), 0);
        tick(30);
        check_output("abort_no_done_valid", int'(result_valid), 0);

        start = 1'b1;
        abort = 1'b1;
        tick(1);
        check_output("start_abort_busy", int'(busy), 0);
        start = 1'b0;
        abort = 1'b0;
        tick(1);
        apply_stimulus(4'h2, 16);
        wait_done();

        // Asynchronous reset in the middle of RUN.
        seed_in = 4'h5;
        start   = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        #3 reset = 1'b0;
        #1;
        check_output("midrst_seed", int'(seed), 0);
        check_output("midrst_enable", int'(enable), 0);
        check_output("midrst_busy", int'(busy), 0);
        check_output("midrst_restart", int'(restart), 0);
        check_output("midrst_result", int'(result), 0);
        check_output("midrst_result_valid", int'(result_valid), 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        apply_stimulus(4'hA, 16);
        check_output("post_rst_seed", int'(seed), 10);
        check_output("post_rst_restart", int'(restart), 1);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/sc_stream_ctrl.md
Name: sc_stream_ctrl

Overview:
- Run controller for one stochastic-computing evaluation window in the Sobel datapath.
- Drives the `seed`/`restart`/`enable` inputs of the LFSR_N_bit_added_zero random generators that feed the stochastic datapath.
- Holds the generators running for one full period (2^N cycles), counts the ones in the returned output bitstream, and publishes the count as a binary result with a start/done handshake.

Parameters:
- N, 8, LFSR width. Window length is 2^N cycles (the added-zero LFSR period).
- PIPE_LAT, 1, cycles from `enable` to the matching `sc_bit` at the datapath output. Range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one evaluation window. Sampled only in IDLE.
- abort  in  1  cancel the current run and return to IDLE.
- seed_in  in  N  seed for the generators, latched when start is accepted.
- sc_bit  in  1  stochastic output bit from the datapath.
- seed  out  N  latched seed, wired to the generators' `.seed`.
- restart  out  1  one-cycle generator reload pulse, wired to `.restart`.
- enable  out  1  generator advance, wired to `.enable`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when `result` updates.
- result  out  N+1  ones count of the last completed window, 0..2^N.
- result_valid  out  1  `result` holds a completed count.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - seed, restart, enable, busy, done, result, result_valid all go to 0.
  - Window counter, accumulator and valid-delay line are cleared.
  - Release is synchronous to the next clk edge.
- States and transitions:
  - IDLE:
    - All strobes low.
    - start=1 at an edge → latch seed_in into `seed`, clear result_valid, go to LOAD.
  - LOAD (1 cycle):
    - restart=1, enable=0.
    - Accumulator and window counter cleared.
    - → RUN.
  - RUN (exactly 2^N cycles):
    - enable=1.
    - Window counter counts 0..2^N-1.
    - Terminal count → DRAIN if PIPE_LAT>0, else DONE.
  - DRAIN (PIPE_LAT cycles):
    - enable=0.
    - Accumulator still sampling the delayed bits.
    - → DONE.
  - DONE (1 cycle):
    - done=1, result_valid=1, `result` shows the final accumulator value.
    - → IDLE.
- Sampling rule:
  - A PIPE_LAT-deep delay line carries `enable`.
  - sc_bit is added to the accumulator only in cycles where delayed enable=1. This gives exactly 2^N samples per window.
  - With PIPE_LAT=0, sampling is in the same cycle as enable.
- Arithmetic:
  - Accumulator is N+1 bits; 2^N ones must not wrap.
  - The window counter is N bits and its terminal count is detected; it must not overflow into an extra cycle.
- Latency:
  - Start sampled at edge e0.
  - done rises after edge e0 + 2^N + PIPE_LAT + 1.
  - done stays high for exactly one cycle.
- Handshake:
  - start is ignored while busy=1. No queuing.
  - start high at the DONE→IDLE edge is not accepted. It is accepted at the next edge if still high.
  - start held high continuously gives back-to-back runs separated by one IDLE cycle.
- abort:
  - abort=1 at any edge in LOAD, RUN or DRAIN → IDLE next cycle.
  - enable and restart drop, no done.
  - result keeps its previous value; result_valid stays 0, having been cleared when the run started.
  - abort in IDLE or DONE has no effect.
  - start and abort high together in IDLE: abort wins, so the run is not started.
- Reset mid-run:
  - Same as reset at power-up.
  - No done is produced.
- Other invariants:
  - `seed` is stable from LOAD through DONE.
  - restart and enable are never high in the same cycle.

Test Plan:
1. N=4, PIPE_LAT=1, sc_bit held 1, start pulse → restart high 1 cycle, enable high 16 cycles, done after 18 edges, result=16, result_valid=1.
2. N=4, sc_bit held 0 → result=0, done timing identical to scenario 1.
3. N=4, PIPE_LAT=1, sc_bit=1 only in the cycle after each of the first 5 enable cycles → result=5. Also drive sc_bit=1 during LOAD and IDLE to confirm those bits are not counted.
4. Assert start again during RUN → ignored, single done. Then hold start high → back-to-back runs, one IDLE cycle between done pulses.
5. abort at RUN cycle 7 → IDLE next cycle, enable=0, no done, result unchanged from the previous run, result_valid=0. A new start then completes normally.
6. Drive reset=0 mid-RUN, asynchronously between edges → all outputs 0 immediately. After release, a new start with seed_in=4'hA gives seed=4'hA during LOAD.
